// File: rtl/soc_periph_apb_bridge.sv
// soc_periph_apb_bridge: single-outstanding request/grant port to APB3 master bridge.
// Latency: APB access responds 3 cycles after grant (+1 per wait state); rejected request responds 1 cycle after grant.
// Backpressure: gnt_o is low outside IDLE, so the requester holds req_i until the bridge is free again.
// Optional feature: define PERIPH_APB_BRIDGE_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES cycles.
module soc_periph_apb_bridge #(
   parameter int unsigned                APB_ADDR_WIDTH = 32,
   parameter int unsigned                APB_DATA_WIDTH = 32,
   parameter logic [APB_ADDR_WIDTH-1:0]  PERIPH_BASE    = 32'h1A10_0000,
   parameter logic [APB_ADDR_WIDTH-1:0]  PERIPH_SIZE    = 32'h0010_0000,
   parameter int unsigned                TIMEOUT_CYCLES = 256
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   // request/grant side
   input  logic                          req_i,
   output logic                          gnt_o,
   input  logic [APB_ADDR_WIDTH-1:0]     addr_i,
   input  logic                          we_i,
   input  logic [APB_DATA_WIDTH/8-1:0]   be_i,
   input  logic [APB_DATA_WIDTH-1:0]     wdata_i,
   output logic                          r_valid_o,
   output logic [APB_DATA_WIDTH-1:0]     r_rdata_o,
   output logic                          r_opc_o,
   // APB3 master side
   output logic [APB_ADDR_WIDTH-1:0]     paddr_o,
   output logic [APB_DATA_WIDTH-1:0]     pwdata_o,
   output logic                          pwrite_o,
   output logic                          psel_o,
   output logic                          penable_o,
   input  logic                          pready_i,
   input  logic [APB_DATA_WIDTH-1:0]     prdata_i,
   input  logic                          pslverr_i
);

   localparam int unsigned BE_W = APB_DATA_WIDTH / 8;

   // A timeout shorter than two cycles cannot cover SETUP->ACCESS sequencing.
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_check
      $error("soc_periph_apb_bridge: TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   state_e                      state_q;
   logic                        psel_q;
   logic                        penable_q;
   logic                        pwrite_q;
   logic [APB_ADDR_WIDTH-1:0]   paddr_q;
   logic [APB_DATA_WIDTH-1:0]   pwdata_q;
   logic                        r_valid_q;
   logic [APB_DATA_WIDTH-1:0]   r_rdata_q;
   logic                        r_opc_q;

`ifdef PERIPH_APB_BRIDGE_TIMEOUT_EN
   localparam int unsigned       TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0]             to_cnt_q;
   logic                        timeout_hit;

   // Last permitted ACCESS cycle reached; combined with pready_i=0 this aborts the transfer.
   assign timeout_hit = (to_cnt_q == TO_LAST);
`endif

   // Range check is a wrapping offset compare so the window may sit anywhere in the map.
   logic [APB_ADDR_WIDTH-1:0]   addr_off;
   logic                        in_range;
   logic                        partial_wr;
   logic                        accept_apb;

   assign addr_off   = addr_i - PERIPH_BASE;
   assign in_range   = (addr_off < PERIPH_SIZE);
   // APB3 has no strobes, so sub-word writes cannot be forwarded; reads ignore be_i.
   assign partial_wr = we_i & (be_i != {BE_W{1'b1}});
   assign accept_apb = in_range & ~partial_wr;

   // Grant only while idle and not in reset; this is the sole combinational output.
   assign gnt_o = req_i & (state_q == IDLE) & ~rst_i;

   // Bridge FSM with registered APB and response outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         r_valid_q <= 1'b0;
         r_rdata_q <= '0;
         r_opc_q   <= 1'b0;
`ifdef PERIPH_APB_BRIDGE_TIMEOUT_EN
         to_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               r_valid_q <= 1'b0;
               if (gnt_o) begin
                  paddr_q  <= addr_i;
                  pwdata_q <= wdata_i;
                  pwrite_q <= we_i;
                  if (accept_apb) begin
                     psel_q  <= 1'b1;
                     state_q <= SETUP;
                  end else begin
                     // Rejected: answer with an error next cycle, never touch the APB bus.
                     r_valid_q <= 1'b1;
                     r_opc_q   <= 1'b1;
                     r_rdata_q <= '0;
                     state_q   <= RESP;
                  end
               end
            end

            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
`ifdef PERIPH_APB_BRIDGE_TIMEOUT_EN
               to_cnt_q  <= '0;
`endif
            end

            ACCESS: begin
               if (pready_i) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  r_valid_q <= 1'b1;
                  r_opc_q   <= pslverr_i;
                  r_rdata_q <= pwrite_q ? '0 : prdata_i;
                  state_q   <= RESP;
               end
`ifdef PERIPH_APB_BRIDGE_TIMEOUT_EN
               else if (timeout_hit) begin
                  // Slave never answered: drop the bus and report an error.
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  r_valid_q <= 1'b1;
                  r_opc_q   <= 1'b1;
                  r_rdata_q <= '0;
                  state_q   <= RESP;
               end else begin
                  to_cnt_q  <= to_cnt_q + TO_W'(1);
               end
`endif
            end

            RESP: begin
               r_valid_q <= 1'b0;
               state_q   <= IDLE;
            end

            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               r_valid_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign psel_o    = psel_q;
   assign penable_o = penable_q;
   assign pwrite_o  = pwrite_q;
   assign paddr_o   = paddr_q;
   assign pwdata_o  = pwdata_q;
   assign r_valid_o = r_valid_q;
   assign r_rdata_o = r_rdata_q;
   assign r_opc_o   = r_opc_q;

endmodule

// File: tb/tb_soc_periph_apb_bridge.sv
// tb_soc_periph_apb_bridge: directed checks of the request/grant to APB3 bridge.
// Inputs change and outputs are sampled on the falling clock edge; the DUT acts on the rising edge.
// The timeout section adapts to whether PERIPH_APB_BRIDGE_TIMEOUT_EN is defined.
module tb_soc_periph_apb_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        r_valid_o;
   logic [31:0] r_rdata_o;
   logic        r_opc_o;
   logic [31:0] paddr_o;
   logic [31:0] pwdata_o;
   logic        pwrite_o;
   logic        psel_o;
   logic        penable_o;
   logic        pready_i;
   logic [31:0] prdata_i;
   logic        pslverr_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   soc_periph_apb_bridge #(
      .APB_ADDR_WIDTH (32),
      .APB_DATA_WIDTH (32),
      .PERIPH_BASE    (32'h1A10_0000),
      .PERIPH_SIZE    (32'h0010_0000),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .gnt_o     (gnt_o),
      .addr_i    (addr_i),
      .we_i      (we_i),
      .be_i      (be_i),
      .wdata_i   (wdata_i),
      .r_valid_o (r_valid_o),
      .r_rdata_o (r_rdata_o),
      .r_opc_o   (r_opc_o),
      .paddr_o   (paddr_o),
      .pwdata_o  (pwdata_o),
      .pwrite_o  (pwrite_o),
      .psel_o    (psel_o),
      .penable_o (penable_o),
      .pready_i  (pready_i),
      .prdata_i  (prdata_i),
      .pslverr_i (pslverr_i)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Request that must be refused: error response one cycle after grant, no APB cycle.
   task automatic reject(input string tag, input logic [31:0] a, input logic w, input logic [3:0] b);
      @(negedge clk_i);
      req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = 32'hA5A5_A5A5;
      #1;
      chk1({tag, " gnt"}, gnt_o, 1'b1);
      @(negedge clk_i);
      req_i = 1'b0;
      chk1 ({tag, " r_valid"}, r_valid_o, 1'b1);
      chk1 ({tag, " opc"},     r_opc_o,   1'b1);
      chk32({tag, " rdata"},   r_rdata_o, 32'h0);
      chk1 ({tag, " psel c1"}, psel_o,    1'b0);
      @(negedge clk_i);
      chk1 ({tag, " r_valid c2"}, r_valid_o, 1'b0);
      chk1 ({tag, " psel c2"},    psel_o,    1'b0);
   endtask

   initial begin
      int vld_seen;
      rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = 4'h0; wdata_i = '0;
      pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;

      // ---------------- reset state ----------------
      @(negedge clk_i);
      @(negedge clk_i);
      chk1 ("rst psel",    psel_o,    1'b0);
      chk1 ("rst penable", penable_o, 1'b0);
      chk1 ("rst pwrite",  pwrite_o,  1'b0);
      chk32("rst paddr",   paddr_o,   32'h0);
      chk32("rst pwdata",  pwdata_o,  32'h0);
      chk1 ("rst r_valid", r_valid_o, 1'b0);
      chk32("rst r_rdata", r_rdata_o, 32'h0);
      chk1 ("rst r_opc",   r_opc_o,   1'b0);
      req_i = 1'b1; #1;
      chk1 ("rst gnt blocked", gnt_o, 1'b0);
      req_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;

      // ---------------- T1: read, zero wait states ----------------
      @(negedge clk_i);                                   // cycle 0
      req_i = 1'b1; addr_i = 32'h1A10_4000; we_i = 1'b0; be_i = 4'hF; #1;
      chk1("t1 gnt", gnt_o, 1'b1);
      @(negedge clk_i);                                   // cycle 1: SETUP
      req_i = 1'b0;
      chk1 ("t1 c1 psel",    psel_o,    1'b1);
      chk1 ("t1 c1 penable", penable_o, 1'b0);
      chk32("t1 c1 paddr",   paddr_o,   32'h1A10_4000);
      chk1 ("t1 c1 pwrite",  pwrite_o,  1'b0);
      pready_i = 1'b1; prdata_i = 32'hCAFE_F00D;
      @(negedge clk_i);                                   // cycle 2: ACCESS
      chk1 ("t1 c2 psel",    psel_o,    1'b1);
      chk1 ("t1 c2 penable", penable_o, 1'b1);
      chk1 ("t1 c2 r_valid", r_valid_o, 1'b0);
      @(negedge clk_i);                                   // cycle 3: RESP
      pready_i = 1'b0; prdata_i = 32'h0;
      chk1 ("t1 c3 r_valid", r_valid_o, 1'b1);
      chk32("t1 c3 rdata",   r_rdata_o, 32'hCAFE_F00D);
      chk1 ("t1 c3 opc",     r_opc_o,   1'b0);
      chk1 ("t1 c3 psel",    psel_o,    1'b0);
      chk1 ("t1 c3 penable", penable_o, 1'b0);
      @(negedge clk_i);                                   // cycle 4: IDLE
      chk1 ("t1 c4 r_valid", r_valid_o, 1'b0);
      chk32("t1 c4 rdata hold", r_rdata_o, 32'hCAFE_F00D);
      chk32("t1 c4 paddr hold", paddr_o,   32'h1A10_4000);

      // ---------------- T2: write, 3 wait states ----------------
      @(negedge clk_i);                                   // cycle 0
      req_i = 1'b1; addr_i = 32'h1A10_2004; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'h1234_5678; #1;
      chk1("t2 gnt", gnt_o, 1'b1);
      @(negedge clk_i);                                   // cycle 1: SETUP
      req_i = 1'b0; wdata_i = 32'h0;
      chk1 ("t2 c1 psel",    psel_o,    1'b1);
      chk1 ("t2 c1 penable", penable_o, 1'b0);
      chk1 ("t2 c1 pwrite",  pwrite_o,  1'b1);
      chk32("t2 c1 pwdata",  pwdata_o,  32'h1234_5678);
      for (int c = 2; c <= 5; c++) begin                  // cycles 2..5: ACCESS
         @(negedge clk_i);
         chk1 ($sformatf("t2 c%0d penable", c), penable_o, 1'b1);
         chk1 ($sformatf("t2 c%0d psel",    c), psel_o,    1'b1);
         chk1 ($sformatf("t2 c%0d pwrite",  c), pwrite_o,  1'b1);
         chk32($sformatf("t2 c%0d pwdata",  c), pwdata_o,  32'h1234_5678);
         chk32($sformatf("t2 c%0d paddr",   c), paddr_o,   32'h1A10_2004);
         chk1 ($sformatf("t2 c%0d r_valid", c), r_valid_o, 1'b0);
         pready_i = (c == 5);
      end
      @(negedge clk_i);                                   // cycle 6: RESP
      pready_i = 1'b0;
      chk1 ("t2 c6 r_valid", r_valid_o, 1'b1);
      chk1 ("t2 c6 opc",     r_opc_o,   1'b0);
      chk32("t2 c6 rdata",   r_rdata_o, 32'h0);
      @(negedge clk_i);
      chk1 ("t2 c7 r_valid", r_valid_o, 1'b0);

      // ---------------- T3: slave error, request held during transfer ----------------
      @(negedge clk_i);                                   // cycle 0
      req_i = 1'b1; addr_i = 32'h1A10_0010; we_i = 1'b0; be_i = 4'hF; #1;
      chk1("t3 gnt c0", gnt_o, 1'b1);
      @(negedge clk_i);                                   // cycle 1: SETUP, req still high
      #1;
      chk1("t3 gnt c1", gnt_o, 1'b0);
      pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'hDEAD_BEEF;
      @(negedge clk_i);                                   // cycle 2: ACCESS
      #1;
      chk1("t3 gnt c2", gnt_o, 1'b0);
      @(negedge clk_i);                                   // cycle 3: RESP
      pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h0; #1;
      chk1 ("t3 gnt c3",   gnt_o,     1'b0);
      chk1 ("t3 r_valid",  r_valid_o, 1'b1);
      chk1 ("t3 opc",      r_opc_o,   1'b1);
      chk32("t3 rdata",    r_rdata_o, 32'hDEAD_BEEF);
      @(negedge clk_i);                                   // cycle 4: IDLE, held request granted
      #1;
      chk1("t3 gnt c4", gnt_o, 1'b1);
      @(negedge clk_i);                                   // cycle 5: SETUP of second access
      req_i = 1'b0;
      chk1("t3b psel", psel_o, 1'b1);
      pready_i = 1'b1; prdata_i = 32'h0000_0042;
      @(negedge clk_i);                                   // cycle 6: ACCESS
      @(negedge clk_i);                                   // cycle 7: RESP
      pready_i = 1'b0; prdata_i = 32'h0;
      chk1 ("t3b r_valid", r_valid_o, 1'b1);
      chk1 ("t3b opc",     r_opc_o,   1'b0);
      chk32("t3b rdata",   r_rdata_o, 32'h0000_0042);
      @(negedge clk_i);

      // ---------------- T4: rejected requests and window boundaries ----------------
      reject("t4 oor read",     32'h1C00_0000, 1'b0, 4'hF);
      reject("t4 partial wr",   32'h1A10_0000, 1'b1, 4'h3);
      reject("t4 above window", 32'h1A20_0000, 1'b0, 4'hF);
      reject("t4 below window", 32'h1A0F_FFFC, 1'b0, 4'hF);
      reject("t4 zero addr",    32'h0000_0000, 1'b0, 4'hF);
      // Last word of the window is accepted.
      @(negedge clk_i);
      req_i = 1'b1; addr_i = 32'h1A1F_FFFC; we_i = 1'b0; be_i = 4'hF; #1;
      chk1("t4 top gnt", gnt_o, 1'b1);
      @(negedge clk_i);
      req_i = 1'b0;
      chk1 ("t4 top psel",  psel_o,  1'b1);
      chk32("t4 top paddr", paddr_o, 32'h1A1F_FFFC);
      pready_i = 1'b1; prdata_i = 32'h7777_0001;
      @(negedge clk_i);
      @(negedge clk_i);
      pready_i = 1'b0;
      chk1 ("t4 top r_valid", r_valid_o, 1'b1);
      chk32("t4 top rdata",   r_rdata_o, 32'h7777_0001);
      @(negedge clk_i);

      // ---------------- T5: reset during ACCESS wait ----------------
      @(negedge clk_i);                                   // cycle 0 (read, be ignored)
      req_i = 1'b1; addr_i = 32'h1A10_0020; we_i = 1'b0; be_i = 4'h0; #1;
      chk1("t5 gnt", gnt_o, 1'b1);
      @(negedge clk_i);                                   // cycle 1: SETUP
      req_i = 1'b0;
      @(negedge clk_i);                                   // cycle 2: ACCESS
      chk1("t5 c2 penable", penable_o, 1'b1);
      @(negedge clk_i);                                   // cycle 3: still waiting
      rst_i = 1'b1;
      @(negedge clk_i);                                   // cycle 4: after reset edge
      chk1 ("t5 psel",    psel_o,    1'b0);
      chk1 ("t5 penable", penable_o, 1'b0);
      chk1 ("t5 r_valid", r_valid_o, 1'b0);
      req_i = 1'b1; addr_i = 32'h1A10_0024; #1;
      chk1 ("t5 gnt in rst", gnt_o, 1'b0);
      @(negedge clk_i);                                   // cycle 5
      chk1 ("t5 r_valid c5", r_valid_o, 1'b0);
      rst_i = 1'b0; #1;
      chk1 ("t5 gnt after rst", gnt_o, 1'b1);
      @(negedge clk_i);                                   // SETUP
      req_i = 1'b0;
      chk1 ("t5 fresh psel", psel_o, 1'b1);
      pready_i = 1'b1; prdata_i = 32'h0BAD_F00D;
      @(negedge clk_i);                                   // ACCESS
      @(negedge clk_i);                                   // RESP
      pready_i = 1'b0;
      chk1 ("t5 fresh r_valid", r_valid_o, 1'b1);
      chk32("t5 fresh rdata",   r_rdata_o, 32'h0BAD_F00D);
      @(negedge clk_i);

      // ---------------- T6: slave never ready ----------------
      @(negedge clk_i);                                   // cycle 0
      req_i = 1'b1; addr_i = 32'h1A10_0030; we_i = 1'b0; be_i = 4'hF; #1;
      chk1("t6 gnt", gnt_o, 1'b1);
      @(negedge clk_i);                                   // cycle 1: SETUP
      req_i = 1'b0; pready_i = 1'b0;
`ifdef PERIPH_APB_BRIDGE_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin                  // 8 ACCESS cycles
         @(negedge clk_i);
         chk1($sformatf("t6 acc%0d penable", k), penable_o, 1'b1);
         chk1($sformatf("t6 acc%0d r_valid", k), r_valid_o, 1'b0);
      end
      @(negedge clk_i);
      chk1 ("t6 to r_valid", r_valid_o, 1'b1);
      chk1 ("t6 to opc",     r_opc_o,   1'b1);
      chk32("t6 to rdata",   r_rdata_o, 32'h0);
      chk1 ("t6 to psel",    psel_o,    1'b0);
      chk1 ("t6 to penable", penable_o, 1'b0);
      @(negedge clk_i);
      chk1 ("t6 to r_valid after", r_valid_o, 1'b0);
`else
      vld_seen = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk_i);
         if (r_valid_o !== 1'b0) vld_seen++;
      end
      checks++;
      assert (vld_seen == 0) else begin
         failures++;
         $error("FAIL t6 no response observed=%0d expected=0", vld_seen);
      end
      chk1("t6 still penable", penable_o, 1'b1);
      chk1("t6 still psel",    psel_o,    1'b1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk1("t6 rst psel", psel_o, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/soc_periph_apb_bridge.md
Name: soc_periph_apb_bridge

Overview:
- Single-outstanding bridge from the SoC interconnect's request/grant peripheral port (TCDM-style) to an APB3 master.
- Drives the slave port of the peripheral bus splitter, which decodes to FLL, GPIO, uDMA, SoC ctrl, timers, EU, HWPE, stdout and debug.
- Performs range check, APB SETUP/ACCESS sequencing, wait-state handling, optional timeout, and returns a one-cycle response.

Parameters:
- APB_ADDR_WIDTH, 32, address width of both sides.
- APB_DATA_WIDTH, 32, data width of both sides; BE width = APB_DATA_WIDTH/8.
- PERIPH_BASE, 32'h1A10_0000, lowest accepted address.
- PERIPH_SIZE, 32'h0010_0000, size of accepted window in bytes.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles; used only with the optional feature; must be >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  APB_ADDR_WIDTH  byte address.
- we_i  in  1  1 = write.
- be_i  in  APB_DATA_WIDTH/8  byte enables.
- wdata_i  in  APB_DATA_WIDTH  write data.
- r_valid_o  out  1  response valid, single cycle.
- r_rdata_o  out  APB_DATA_WIDTH  read data.
- r_opc_o  out  1  1 = error response.
- paddr_o  out  APB_ADDR_WIDTH  APB address.
- pwdata_o  out  APB_DATA_WIDTH  APB write data.
- pwrite_o  out  1  APB write.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pready_i  in  1  APB ready.
- prdata_i  in  APB_DATA_WIDTH  APB read data.
- pslverr_i  in  1  APB slave error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Reset (sync, rst_i=1 at edge) → IDLE. All registered outputs go to 0: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, r_valid_o, r_rdata_o, r_opc_o. The timeout counter is cleared.
- Reset mid-transfer aborts immediately. psel_o/penable_o are 0 from the cycle after the reset edge. No response is issued for the aborted request.
- gnt_o = req_i & (state==IDLE) & ~rst_i. This is combinational; it is the only combinational output.
- On grant, latch addr, we, wdata.
  - In range (addr_i - PERIPH_BASE < PERIPH_SIZE, unsigned, APB_ADDR_WIDTH wrap) and not a partial write: → SETUP.
  - Out of range, or we_i=1 with be_i != all-ones: → RESP with r_opc_o=1, r_rdata_o=0. No APB cycle. Reads ignore be_i.
- SETUP: psel_o=1, penable_o=0, paddr/pwdata/pwrite stable. Next cycle → ACCESS unconditionally.
- ACCESS: psel_o=1, penable_o=1.
  - pready_i=1 → capture prdata_i into r_rdata_o (reads only; writes give 0) and pslverr_i into r_opc_o, then → RESP.
  - pready_i=0 → hold ACCESS; all APB outputs stay stable.
- RESP: r_valid_o=1 for exactly one cycle, psel_o=penable_o=0, then → IDLE.
- Minimum latency:
  - APB access: grant at cycle 0, SETUP at 1, ACCESS at 2, r_valid_o at 3 with zero wait states; +1 cycle per wait state.
  - Rejected request: r_valid_o at cycle 1.
- Throughput: at most one request per 4 cycles for APB accesses. gnt_o is 0 in SETUP/ACCESS/RESP, so back-to-back requests wait in IDLE.
- paddr_o is forwarded unmodified (no base subtraction).
- paddr_o/pwdata_o retain their last value after a transfer completes.
- r_rdata_o/r_opc_o are valid only while r_valid_o=1. Outside that they hold their last value.

Optional Feature:
- Macro: PERIPH_APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on SETUP→ACCESS and increments each ACCESS cycle with pready_i=0.
  - When it reaches TIMEOUT_CYCLES-1 with pready_i still 0, the next state is RESP with r_opc_o=1 and r_rdata_o=0; psel_o/penable_o drop.
  - pready_i=1 in that same cycle takes priority: normal completion.
- Undefined: no counter; ACCESS waits indefinitely for pready_i.

Test Plan:
- Read 0x1A10_4000, slave pready=1 immediately, prdata=0xCAFE_F00D:
  - psel at cycle 1, penable at cycle 2.
  - r_valid at cycle 3 with rdata=0xCAFE_F00D, opc=0.
- Write 0x1A10_2004, be=4'hF, wdata=0x1234_5678, slave inserts 3 wait states:
  - pwrite=1, pwdata stable for all 4 ACCESS cycles.
  - r_valid at cycle 6, opc=0.
- Read 0x1C00_0000 (out of range), then write 0x1A10_0000 with be=4'h3:
  - Each yields r_valid one cycle after grant, opc=1, rdata=0.
  - psel never asserted.
- Read with pslverr=1 on completion → r_valid with opc=1. A request held during the transfer sees gnt=0 until IDLE, then is granted.
- rst_i asserted during ACCESS wait:
  - Next cycle psel=penable=0, state IDLE, no r_valid.
  - A fresh request is granted the cycle after rst_i deasserts.
- With PERIPH_APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never ready:
  - r_valid with opc=1 after exactly 8 ACCESS cycles.
  - Without the macro, no response within 1000 cycles.
